// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises CPU instruction-fetch and data requests onto a
// single multi-cycle RAM port and returns one-cycle hit pulses.
//
// Ports:
//   CLK, nRST           clock (rising edge), asynchronous active-low reset
//   iREN, iaddr         instruction read request / address (held until ihit)
//   ihit, iload         instruction completion pulse / fetched word
//   dREN, dWEN          data read / write request (held until dhit)
//   daddr, dstore       data address / write data
//   dhit, dload         data completion pulse / read word
//   halt                blocks new grants while high
//   ramREN, ramWEN      RAM strobes
//   ramaddr, ramstore   RAM address / write data
//   ramload, ramstate   RAM read data / status (FREE, BUSY, ACCESS, ERROR)
//   mem_err             sticky error flag (cleared only by reset)
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              ihit,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dhit,
  output logic [DATA_W-1:0] dload,
  input  logic              halt,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              mem_err
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    RAM_FREE   = 2'd0,
    RAM_BUSY   = 2'd1,
    RAM_ACCESS = 2'd2,
    RAM_ERROR  = 2'd3
  } ram_state_e;

  typedef enum logic [2:0] {
    IDLE,
    IACC,
    DACC,
    IHIT,
    DHIT,
    ERR
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] store_q, store_d;
  logic              wr_q, wr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_grant_q, last_grant_d;  // 1: last completed grant was data
  logic [DATA_W-1:0] iload_q, iload_d;
  logic [DATA_W-1:0] dload_q, dload_d;
  logic              dreq;

  assign dreq = dREN | dWEN;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      store_q      <= '0;
      wr_q         <= 1'b0;
      cnt_q        <= '0;
      last_grant_q <= 1'b0;
      iload_q      <= '0;
      dload_q      <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      store_q      <= store_d;
      wr_q         <= wr_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      iload_q      <= iload_d;
      dload_q      <= dload_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    store_d      = store_q;
    wr_d         = wr_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    iload_d      = iload_q;
    dload_d      = dload_q;

    unique case (state_q)
      IDLE: begin
        if (!halt) begin
          // Data wins a tie unless data was the previous grant.
          if (dreq && (!iREN || !last_grant_q)) begin
            addr_d  = daddr;
            store_d = dWEN ? dstore : '0;
            wr_d    = dWEN;
            cnt_d   = '0;
            state_d = DACC;
          end else if (iREN) begin
            addr_d  = iaddr;
            store_d = '0;
            wr_d    = 1'b0;
            cnt_d   = '0;
            state_d = IACC;
          end
        end
      end
      IACC, DACC: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (ramstate == RAM_ACCESS) begin
          if (state_q == IACC) begin
            iload_d      = ramload;
            last_grant_d = 1'b0;
            state_d      = IHIT;
          end else begin
            if (!wr_q) begin
              dload_d = ramload;
            end
            last_grant_d = 1'b1;
            state_d      = DHIT;
          end
        end else if (ramstate == RAM_ERROR || cnt_q == CNT_LAST) begin
          state_d = ERR;
        end
      end
      IHIT, DHIT: state_d = IDLE;
      ERR:        state_d = ERR;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    unique case (state_q)
      IACC: begin
        ramREN  = 1'b1;
        ramaddr = addr_q;
      end
      DACC: begin
        ramREN   = !wr_q;
        ramWEN   = wr_q;
        ramaddr  = addr_q;
        ramstore = store_q;
      end
      default: ;
    endcase
  end

  assign ihit    = (state_q == IHIT);
  assign dhit    = (state_q == DHIT);
  assign mem_err = (state_q == ERR);
  assign iload   = iload_q;
  assign dload   = dload_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios followed by random request
// traffic, checked against a transaction-level model (round-robin tie rule,
// RAM contents, expected latency and load values).
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic          iREN = 1'b0;
  logic [AW-1:0] iaddr = '0;
  logic          ihit;
  logic [DW-1:0] iload;
  logic          dREN = 1'b0;
  logic          dWEN = 1'b0;
  logic [AW-1:0] daddr = '0;
  logic [DW-1:0] dstore = '0;
  logic          dhit;
  logic [DW-1:0] dload;
  logic          halt = 1'b0;
  logic          ramREN;
  logic          ramWEN;
  logic [AW-1:0] ramaddr;
  logic [DW-1:0] ramstore;
  logic [DW-1:0] ramload = '0;
  logic [1:0]    ramstate = 2'd0;
  logic          mem_err;

  always #5 CLK = ~CLK;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dhit(dhit), .dload(dload), .halt(halt),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .mem_err(mem_err)
  );

  int n_chk = 0;
  int n_pass = 0;

  // Reference model state
  bit          m_last = 1'b0;   // 1: last completed grant was data
  logic [31:0] m_iload = '0;
  logic [31:0] m_dload = '0;
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] x;
    x = 32'($urandom_range(0, 15)) << 2;
    return x;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ihit"}, 64'(ihit), 64'd0);
    chk({tag, "_dhit"}, 64'(dhit), 64'd0);
    chk({tag, "_iload"}, 64'(iload), 64'd0);
    chk({tag, "_dload"}, 64'(dload), 64'd0);
    chk({tag, "_ramREN"}, 64'(ramREN), 64'd0);
    chk({tag, "_ramWEN"}, 64'(ramWEN), 64'd0);
    chk({tag, "_ramaddr"}, 64'(ramaddr), 64'd0);
    chk({tag, "_ramstore"}, 64'(ramstore), 64'd0);
    chk({tag, "_mem_err"}, 64'(mem_err), 64'd0);
  endtask

  task automatic model_reset();
    m_last  = 1'b0;
    m_iload = '0;
    m_dload = '0;
  endtask

  task automatic do_reset();
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; halt = 1'b0; ramstate = 2'd0;
    nRST = 1'b0;
    #1;
    chk_all_zero("reset");
    step();
    step();
    nRST = 1'b1;
    model_reset();
    step();
  endtask

  // One complete transaction starting at a negedge in IDLE with requests
  // already driven. The model picks the winner; RAM answers ACCESS after
  // 'lat' BUSY cycles.
  task automatic txn(input int lat, input bit drop, input bit halt_mid);
    bit          gd;
    bit          w;
    logic [31:0] a;
    logic [31:0] s;
    gd = (dREN | dWEN) && (!iREN || !m_last);
    w  = gd && dWEN;
    a  = gd ? daddr : iaddr;
    s  = dstore;
    chk("idle_ramREN", 64'(ramREN), 64'd0);
    chk("idle_hits", 64'({ihit, dhit}), 64'd0);
    step();
    for (int k = 0; k <= lat; k++) begin
      chk("acc_ramREN", 64'(ramREN), 64'(!w));
      chk("acc_ramWEN", 64'(ramWEN), 64'(w));
      chk("acc_ramaddr", 64'(ramaddr), 64'(a));
      if (w) chk("acc_ramstore", 64'(ramstore), 64'(s));
      chk("acc_nohit", 64'({ihit, dhit}), 64'd0);
      if (k == 0 && drop) begin
        if (gd) begin dREN = 1'b0; dWEN = 1'b0; end
        else iREN = 1'b0;
      end
      if (k == 0 && halt_mid) halt = 1'b1;
      if (k == lat) begin
        ramstate = 2'd2;
        ramload  = w ? $urandom : mem_rd(a);
      end else begin
        ramstate = 2'd1;
        ramload  = $urandom;
      end
      step();
    end
    ramstate = 2'd0;
    if (gd) begin
      if (w) mem[a] = s;
      else m_dload = mem_rd(a);
      m_last = 1'b1;
    end else begin
      m_iload = mem_rd(a);
      m_last  = 1'b0;
    end
    chk("hit_ihit", 64'(ihit), 64'(!gd));
    chk("hit_dhit", 64'(dhit), 64'(gd));
    chk("hit_strobes", 64'({ramREN, ramWEN}), 64'd0);
    chk("hit_iload", 64'(iload), 64'(m_iload));
    chk("hit_dload", 64'(dload), 64'(m_dload));
    if (gd) begin dREN = 1'b0; dWEN = 1'b0; end
    else iREN = 1'b0;
    step();
    chk("post_hit", 64'({ihit, dhit}), 64'd0);
  endtask

  initial begin
    // Reset state
    #1;
    chk_all_zero("por");
    @(negedge CLK);
    nRST = 1'b1;
    step();

    // Instruction fetch, ACCESS on the second access cycle
    mem[32'h40] = 32'h2402_0005;
    iREN = 1'b1; iaddr = 32'h40;
    txn(1, 1'b0, 1'b0);
    chk("tp1_iload", 64'(iload), 64'h2402_0005);

    // Simultaneous requests after reset: data first, then instruction
    do_reset();
    iREN = 1'b1; iaddr = 32'h44;
    dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEAD_BEEF;
    txn(0, 1'b0, 1'b0);
    dWEN = 1'b1; daddr = 32'h104; dstore = 32'h0BAD_CAFE;
    txn(0, 1'b0, 1'b0);
    chk("tp2_iload", 64'(iload), 64'(32'h44 ^ 32'h5A5A_0000));
    txn(0, 1'b0, 1'b0);
    dREN = 1'b1; daddr = 32'h100;
    txn(0, 1'b0, 1'b0);
    chk("tp2_readback", 64'(dload), 64'hDEAD_BEEF);

    // Requester drops dREN after grant; access still completes
    mem[32'h80] = 32'h0000_1234;
    dREN = 1'b1; daddr = 32'h80;
    txn(0, 1'b1, 1'b0);
    chk("tp3_dload", 64'(dload), 64'h1234);

    // dREN and dWEN together are treated as a write
    dREN = 1'b1; dWEN = 1'b1; daddr = 32'h84; dstore = 32'h1111_2222;
    txn(0, 1'b0, 1'b0);
    chk("both_dload_kept", 64'(dload), 64'h1234);

    // halt raised mid-write: write completes, then no grants while halted
    dWEN = 1'b1; daddr = 32'h88; dstore = 32'hCAFE_F00D;
    txn(1, 1'b0, 1'b1);
    iREN = 1'b1; iaddr = 32'h48;
    for (int k = 0; k < 4; k++) begin
      chk("halt_ramREN", 64'(ramREN), 64'd0);
      chk("halt_ihit", 64'(ihit), 64'd0);
      step();
    end
    halt = 1'b0;
    txn(0, 1'b0, 1'b0);

    // ACCESS on the final cycle before timeout still succeeds
    iREN = 1'b1; iaddr = 32'h88;
    txn(TO - 1, 1'b0, 1'b0);
    chk("late_access_iload", 64'(iload), 64'hCAFE_F00D);
    chk("late_access_err", 64'(mem_err), 64'd0);

    // RAM reports ERROR
    iREN = 1'b1; iaddr = 32'h4C;
    step();
    chk("rerr_ramREN", 64'(ramREN), 64'd1);
    ramstate = 2'd3;
    step();
    ramstate = 2'd0;
    chk("rerr_mem_err", 64'(mem_err), 64'd1);
    chk("rerr_strobes", 64'({ramREN, ramWEN}), 64'd0);
    do_reset();

    // Timeout: BUSY for TIMEOUT access cycles
    iREN = 1'b1; iaddr = 32'h50;
    step();
    for (int k = 0; k < TO; k++) begin
      chk("to_ramREN", 64'(ramREN), 64'd1);
      chk("to_mem_err", 64'(mem_err), 64'd0);
      ramstate = 2'd1;
      step();
    end
    ramstate = 2'd2;
    for (int k = 0; k < 3; k++) begin
      chk("to_err_sticky", 64'(mem_err), 64'd1);
      chk("to_strobes", 64'({ramREN, ramWEN}), 64'd0);
      chk("to_nohit", 64'({ihit, dhit}), 64'd0);
      step();
    end
    do_reset();
    chk("to_err_cleared", 64'(mem_err), 64'd0);

    // Load a nonzero iload, then reset in the middle of a fetch
    mem[32'h54] = 32'h7777_0001;
    iREN = 1'b1; iaddr = 32'h54;
    txn(0, 1'b0, 1'b0);
    iREN = 1'b1; iaddr = 32'h58;
    step();
    chk("mid_ramREN", 64'(ramREN), 64'd1);
    #2 nRST = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    @(negedge CLK);
    chk("mid_reset_nohit", 64'(ihit), 64'd0);
    step();
    nRST = 1'b1;
    model_reset();
    txn(0, 1'b0, 1'b0);

    // Random traffic
    for (int n = 0; n < 60; n++) begin
      if (!iREN && $urandom_range(0, 2) != 0) begin
        iREN = 1'b1; iaddr = rand_addr();
      end
      if (!(dREN | dWEN) && $urandom_range(0, 2) != 0) begin
        int r;
        r = int'($urandom_range(0, 3));
        dREN = (r == 0 || r == 3);
        dWEN = (r != 0);
        daddr = rand_addr();
        dstore = $urandom;
      end
      if (!iREN && !dREN && !dWEN) begin
        iREN = 1'b1; iaddr = rand_addr();
      end
      txn(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Memory-side responder for the CPU request signals.
- Accepts instruction-fetch requests (iREN) and data requests (dREN/dWEN) from the datapath and control unit.
- Serialises them onto a single multi-cycle RAM port.
- Returns one-cycle ihit/dhit pulses with registered load data, which the control unit uses for PC_EN and RegWEN gating.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data word width.
- TIMEOUT, 64, max cycles waiting for ramstate==ACCESS before flagging error (>=2).

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- iREN  in  1  instruction read request, held until ihit.
- iaddr  in  ADDR_W  instruction address.
- ihit  out  1  one-cycle instruction completion pulse.
- iload  out  DATA_W  fetched instruction, valid when ihit.
- dREN  in  1  data read request, held until dhit.
- dWEN  in  1  data write request, held until dhit.
- daddr  in  ADDR_W  data address.
- dstore  in  DATA_W  write data.
- dhit  out  1  one-cycle data completion pulse.
- dload  out  DATA_W  read data, valid when dhit.
- halt  in  1  CPU halt; blocks new grants.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  ADDR_W  RAM address.
- ramstore  out  DATA_W  RAM write data.
- ramload  in  DATA_W  RAM read data, valid when ramstate==ACCESS.
- ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR.
- mem_err  out  1  sticky error flag.

Behaviour:
- Reset (async, nRST low):
  - State IDLE.
  - All outputs 0: ihit, dhit, iload, dload, ram* outputs, mem_err.
  - Latches cleared; last_grant_d=0.
- States: IDLE, IACC, DACC, IHIT, DHIT, ERR.
- IDLE:
  - If halt=1, no grant; stay IDLE.
  - Otherwise, when both dREN|dWEN and iREN are pending: grant instruction if last_grant_d=1, else grant data.
  - Only one side pending: grant it.
  - On grant, latch addr/store/kind (read or write) into registers, clear the wait counter, and go to IACC or DACC.
  - dREN and dWEN both high: treat as a write (dWEN wins).
- IACC / DACC:
  - ramaddr/ramstore/ramREN/ramWEN are driven from the latches, not the live inputs.
  - The latched request runs to completion even if the requester drops it, so a write is never aborted.
  - Wait counter increments each cycle.
  - ramstate==ACCESS: capture ramload into iload/dload (reads only; dload unchanged for writes) and go to IHIT/DHIT.
    - last_grant_d = 1 for DACC, 0 for IACC.
  - ramstate==ERROR, or counter reaching TIMEOUT-1 without ACCESS: go to ERR.
- IHIT / DHIT:
  - Corresponding hit is high for exactly this one cycle; ram strobes are 0.
  - New requests are ignored.
  - Next state is IDLE.
  - Minimum request-to-hit latency is 3 cycles (grant, ACCESS, HIT), given ACCESS on the first access cycle.
- iload/dload hold their value until the next completed read of the same kind.
- ERR: mem_err=1, all strobes 0, no hits; remain in ERR until nRST.
- halt asserted mid-access: the access completes and its hit is issued; then stay IDLE while halt=1.
- Reset mid-access: everything returns to reset values immediately; no hit is issued.

Test Plan:
- Reset, then iREN=1 with iaddr=0x0000_0040; RAM returns ACCESS on 2nd access cycle with ramload=0x2402_0005 -> ramREN=1 and ramaddr=0x40 for 2 cycles; ihit pulses 1 cycle; iload=0x2402_0005.
- iREN=1 and dWEN=1 together in IDLE after reset, daddr=0x100, dstore=0xDEAD_BEEF -> data granted first: ramWEN=1, ramstore=0xDEADBEEF; dhit; next grant is instruction even though dWEN is held; ihit follows.
- dREN=1 at daddr=0x80, deasserted one cycle after grant; RAM gives ACCESS with ramload=0x1234 -> access completes; dhit pulses; dload=0x1234.
- iREN=1; RAM holds BUSY for TIMEOUT cycles -> mem_err=1, strobes 0, no ihit; stays set until nRST low.
- halt=1 while a DACC write is in flight -> write completes and dhit pulses; subsequent iREN=1 gets no grant; ramREN stays 0.
- nRST pulsed low during IACC -> all outputs 0 at once; no ihit; after release, a fresh iREN is granted normally.
